// File: rtl/pipeline_dcache.sv
// Direct-mapped write-back/write-allocate data cache for the MIPS MEM stage.
// Optional counters stat_hits/stat_misses/stat_wbs are built when DCACHE_STATS_EN is defined.
module pipeline_dcache #(
    parameter int LINES  = 64,
    parameter int WORDS  = 8,
    parameter int MEM_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbs,
`endif
    output logic [2:0]        dbg_state
);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam int CW    = OFF_W + 1;
    localparam logic [CW-1:0]    CNT_WB_LAST = CW'(WORDS - 1);
    localparam logic [CW-1:0]    CNT_RF_LAST = CW'(WORDS);
    localparam logic [IDX_W-1:0] LINE_LAST   = IDX_W'(LINES - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WB         = 3'd1;
    localparam logic [2:0] S_REFILL     = 3'd2;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
    localparam logic [2:0] S_FLUSH_WB   = 3'd4;

    logic [LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES*WORDS];
    logic [2:0]       state_q;
    logic [CW-1:0]    cnt_q, cnt_m1;
    logic [IDX_W-1:0] line_q, wb_idx;
    logic             flush_pend_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             req, hit, store_hit, refill_cap, refill_last, wb_last;
    logic [29:0]      wb_waddr, rf_waddr;

    assign req_tag = cpu_addr[31:32-TAG_W];
    assign req_idx = cpu_addr[OFF_W+2+:IDX_W];
    assign req_off = cpu_addr[2+:OFF_W];
    assign req     = cpu_re | cpu_we;
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign cnt_m1  = cnt_q - 1'b1;
    assign wb_idx  = (state_q == S_FLUSH_WB) ? line_q : req_idx;
    assign wb_waddr = {tag_q[wb_idx], wb_idx, cnt_q[OFF_W-1:0]};
    assign rf_waddr = {req_tag, req_idx, cnt_q[OFF_W-1:0]};

    assign store_hit   = !rst && state_q == S_IDLE && cpu_we && hit;
    assign refill_cap  = !rst && state_q == S_REFILL && cnt_q != '0;
    assign refill_last = !rst && state_q == S_REFILL && cnt_q == CNT_RF_LAST;
    assign wb_last     = (state_q == S_WB || state_q == S_FLUSH_WB) && cnt_q == CNT_WB_LAST;

    assign dbg_state = state_q;
    assign cpu_rdata = valid_q[req_idx] ? data_q[{req_idx, req_off}] : 32'd0;

    // Handshake: while cpu_stall is high the MEM stage holds cpu_re/cpu_we/cpu_addr/cpu_wdata
    // unchanged; a load completes in the first cycle where cpu_re & ~cpu_stall.
    always_comb begin
        cpu_stall  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        flush_done = 1'b0;
        case (state_q)
            S_IDLE: cpu_stall = req & ~hit;
            S_WB, S_FLUSH_WB: begin
                cpu_stall  = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = wb_waddr[MEM_AW-1:0];
                mem_din    = data_q[{wb_idx, cnt_q[OFF_W-1:0]}];
                flush_done = state_q == S_FLUSH_WB && wb_last && line_q == LINE_LAST;
            end
            S_REFILL: begin
                cpu_stall = 1'b1;
                mem_addr  = rf_waddr[MEM_AW-1:0];
            end
            S_FLUSH_SCAN: begin
                cpu_stall  = 1'b1;
                flush_done = !(valid_q[line_q] && dirty_q[line_q]) && line_q == LINE_LAST;
            end
            default: cpu_stall = 1'b1;
        endcase
    end

    // Line storage carries no reset; only valid/dirty define cache contents.
    always_ff @(posedge clk) begin
        if (store_hit)   data_q[{req_idx, req_off}] <= cpu_wdata;
        if (refill_cap)  data_q[{req_idx, cnt_m1[OFF_W-1:0]}] <= mem_dout;
        if (refill_last) tag_q[req_idx] <= req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_q | flush_req;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (cpu_we) dirty_q[req_idx] <= 1'b1;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB : S_REFILL;
                        end
                    end else if (flush_req || flush_pend_q) begin
                        flush_pend_q <= 1'b0;
                        line_q       <= '0;
                        state_q      <= S_FLUSH_SCAN;
                    end
                end
                S_WB: begin
                    if (wb_last) begin
                        cnt_q   <= '0;
                        state_q <= S_REFILL;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                S_REFILL: begin
                    if (cnt_q == CNT_RF_LAST) begin
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                        cnt_q            <= '0;
                        state_q          <= S_IDLE;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                S_FLUSH_SCAN: begin
                    if (valid_q[line_q] && dirty_q[line_q]) begin
                        cnt_q   <= '0;
                        state_q <= S_FLUSH_WB;
                    end else if (line_q == LINE_LAST) begin
                        line_q  <= '0;
                        state_q <= S_IDLE;
                    end else line_q <= line_q + 1'b1;
                end
                S_FLUSH_WB: begin
                    if (wb_last) begin
                        cnt_q           <= '0;
                        dirty_q[line_q] <= 1'b0;
                        line_q          <= line_q + 1'b1;
                        state_q         <= (line_q == LINE_LAST) ? S_IDLE : S_FLUSH_SCAN;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbs    <= '0;
        end else begin
            if (state_q == S_IDLE && req && hit && stat_hits != '1)
                stat_hits <= stat_hits + 1'b1;
            if (state_q == S_IDLE && req && !hit && stat_misses != '1)
                stat_misses <= stat_misses + 1'b1;
            if (wb_last && stat_wbs != '1)
                stat_wbs <= stat_wbs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_dcache.sv
// Directed bench for pipeline_dcache: hits, clean/dirty misses, flush, reset abort.
module tb_pipeline_dcache;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re, cpu_we, flush_req;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, flush_done, mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic [2:0]  dbg_state;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_wbs;
`endif

    logic [31:0] ram [0:8191];
    logic [44:0] exp_q[$];
    logic [44:0] exp_item;
    int total = 0;
    int bad = 0;
    int wr_count = 0;

    always #5 clk = ~clk;

    pipeline_dcache dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
`ifdef DCACHE_STATS_EN
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs),
`endif
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Word-wide RAM with one-cycle read latency.
    always @(posedge clk) begin
        mem_dout <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_din;
    end

    // Scoreboard: every write strobe must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_count++;
            if (exp_q.size() == 0) check("wb_extra", 64'(mem_addr), 64'h1_0000);
            else begin
                exp_item = exp_q.pop_front();
                check("wb", {19'd0, mem_addr, mem_din}, {19'd0, exp_item});
            end
        end
    end

    task automatic wait_hit(output int n);
        n = 0;
        @(negedge clk);
        while (cpu_stall && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int wr_base;
        bit done;
        rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; flush_req = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 8192; i++) ram[i] = 32'd0;
        ram[2] = 32'd17;
        for (int i = 0; i < 8; i++) begin
            ram[512 + i] = 32'd100 + 32'(i);
            ram[8 + i]   = 32'd200 + 32'(i);
            ram[16 + i]  = 32'd300 + 32'(i);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(cpu_stall), 0);
        check("rst_done", 64'(flush_done), 0);
        check("rst_we", 64'(mem_we), 0);
        check("rst_addr", 64'(mem_addr), 0);
        check("rst_din", 64'(mem_din), 0);
        check("rst_rdata", 64'(cpu_rdata), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean miss on line 0, then immediate re-hit.
        cpu_re = 1'b1; cpu_addr = 32'h0000_0008;
        wait_hit(n);
        check("s1_stalls", 64'(n), 10);
        check("s1_rdata", 64'(cpu_rdata), 17);
        @(posedge clk); #1;
        @(negedge clk);
        check("s2_stall", 64'(cpu_stall), 0);
        check("s2_rdata", 64'(cpu_rdata), 17);
        check("s2_we", 64'(mem_we), 0);

        // Store hit dirties line 0; conflicting load forces write-back then refill.
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h0000_000C; cpu_wdata = 32'd99;
        @(negedge clk);
        check("s3_st_stall", 64'(cpu_stall), 0);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({13'(i), (i == 2) ? 32'd17 : (i == 3) ? 32'd99 : 32'd0});
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h0000_080C;
        wait_hit(n);
        check("s3_stalls", 64'(n), 18);
        check("s3_rdata", 64'(cpu_rdata), 103);
`ifdef DCACHE_STATS_EN
        check("stat_hits", 64'(stat_hits), 3);
        check("stat_misses", 64'(stat_misses), 2);
        check("stat_wbs", 64'(stat_wbs), 1);
`endif
        check("s3_wb_left", 64'(exp_q.size()), 0);
        check("s3_ram3", 64'(ram[3]), 99);

        // Store miss allocates line 1, then flush writes only that line back.
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'd5;
        wait_hit(n);
        check("s4_stalls", 64'(n), 10);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({13'(8 + i), (i == 0) ? 32'd5 : 32'd200 + 32'(i)});
        @(posedge clk); #1;
        cpu_we = 1'b0; flush_req = 1'b1;
        wr_base = wr_count;
        @(negedge clk);
        check("s4_idle_stall", 64'(cpu_stall), 0);
        @(posedge clk); #1;
        flush_req = 1'b0;
        n = 0; done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (flush_done) done = 1'b1;
        end
        check("s4_flush_cycles", 64'(n), 72);
        check("s4_flush_stall", 64'(cpu_stall), 1);
        @(negedge clk);
        check("s4_done_pulse", 64'(flush_done), 0);
        check("s4_after_stall", 64'(cpu_stall), 0);
        check("s4_writes", 64'(wr_count - wr_base), 8);
        check("s4_wb_left", 64'(exp_q.size()), 0);
        check("s4_ram8", 64'(ram[8]), 5);
        check("s4_ram9", 64'(ram[9]), 201);

        // Reset in REFILL cycle 4 aborts the miss and invalidates every line.
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_addr = 32'h0000_0040;
        repeat (4) @(posedge clk);
        #1;
        check("s5_in_refill", 64'(dbg_state), 2);
        rst = 1'b1; cpu_re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("s5_stall", 64'(cpu_stall), 0);
        check("s5_we", 64'(mem_we), 0);
        check("s5_idle", 64'(dbg_state), 0);
        cpu_re = 1'b1; cpu_addr = 32'h0000_0040;
        wait_hit(n);
        check("s5_stalls", 64'(n), 10);
        check("s5_rdata", 64'(cpu_rdata), 300);
        @(posedge clk); #1;
        cpu_addr = 32'h0000_080C;
        wait_hit(n);
        check("s5_inval_stalls", 64'(n), 10);
        check("s5_inval_rdata", 64'(cpu_rdata), 103);
        @(posedge clk); #1;
        cpu_re = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
